// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - B-memory zero-init controller and two-requester round-robin arbiter
module bmem_arbiter #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            init_done,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    output logic            rsp_err,
    output logic [DW-1:0]   rsp_data,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next;
    logic          prio, prio_next;
    logic          rd_pending;

    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_in_range;
    logic          accept;

    always_comb begin
        win          = (req_valid == 2'b11) ? prio : req_valid[1];
        win_we       = win ? req_we[1] : req_we[0];
        win_addr     = win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        win_wdata    = win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        win_in_range = ({1'b0, win_addr} < DEPTH_W);
    end

    // The reset cycle already presents INIT behaviour: zero-write to address 0, nothing granted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        prio_next  = prio;
        accept     = 1'b0;
        init_done  = 1'b0;
        req_ready  = 2'b00;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (rst) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
        end else if (state == INIT) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = cnt;
            if (cnt == LAST_ADDR) begin
                state_next = RUN;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + AW'(1);
            end
        end else begin
            init_done = 1'b1;
            if (clr) begin
                state_next = INIT;
                cnt_next   = '0;
            end else if (req_valid != 2'b00) begin
                accept    = 1'b1;
                req_ready = win ? 2'b10 : 2'b01;
                prio_next = ~win;
                if (win_in_range) begin
                    mem_en    = 1'b1;
                    mem_we    = win_we;
                    mem_addr  = win_addr;
                    mem_wdata = win_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            prio       <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            prio       <= prio_next;
            rsp_valid  <= accept ? (win ? 2'b10 : 2'b01) : 2'b00;
            rsp_err    <= accept & ~win_in_range;
            rd_pending <= accept & win_in_range & ~win_we;
        end
    end

    // Read data arrives from the macro in the response cycle, so it is steered rather than re-registered.
    assign rsp_data = rd_pending ? mem_rdata : '0;

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - randomized self-checking bench for bmem_arbiter
module tb_bmem_arbiter;
    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            rst, clr;
    logic            init_done;
    logic [1:0]      req_valid, req_ready, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    int exp_prio = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    bmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: synchronous write, one-cycle read latency.
    logic          fill_ones = 1'b0;
    logic [DW-1:0] bmem [16];
    always @(posedge clk) begin
        if (fill_ones) begin
            for (int i = 0; i < 16; i++) bmem[i] <= '1;
        end else if (mem_en) begin
            if (mem_we) bmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= bmem[mem_addr];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_addr = {4'd2, 4'd1}; req_wdata = '0;
        step(); step();
        #1;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'd0, 32'd0}) begin
            errors++; $display("FAIL reset_mem got en=%b we=%b a=%0d d=%h want 1 1 0 0", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== 35'd0) begin
            errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_data); end
        fill_ones = 1'b1;
        step();
        fill_ones = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'(i), 32'd0}) begin
                errors++; $display("FAIL init_write%0d got en=%b we=%b a=%0d d=%h want 1 1 %0d 0", i, mem_en, mem_we, mem_addr, mem_wdata, i); end
            checks++; if (req_ready !== 2'b00 || init_done !== 1'b0) begin
                errors++; $display("FAIL init_ready%0d got ready=%b done=%b want 00 0", i, req_ready, init_done); end
            if (i == DEPTH - 1) req_valid = 2'b00;
            step();
        end
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise got %b want 1", init_done); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bmem[i] !== 32'd0) begin errors++; $display("FAIL init_zero%0d got %h want 0", i, bmem[i]); end
            ref_mem[i] = '0;
        end
        exp_prio = 0;
    endtask

    task automatic test_write_read;
        req_valid = 2'b01; req_we = 2'b01; req_addr = {4'd0, 4'd3}; req_wdata = {32'd0, 32'hDEAD_BEEF};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got %b want 01", req_ready); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_mem got en=%b we=%b a=%0d d=%h want 1 1 3 deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'd0}) begin
            errors++; $display("FAIL wr_rsp got v=%b e=%b d=%h want 01 0 0", rsp_valid, rsp_err, rsp_data); end
        req_we = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rd_issue got ready=%b en=%b we=%b want 01 1 0", req_ready, mem_en, mem_we); end
        step();
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL rd_rsp got v=%b e=%b d=%h want 01 0 deadbeef", rsp_valid, rsp_err, rsp_data); end
        ref_mem[3] = 32'hDEAD_BEEF;
        exp_prio = 1;
    endtask

    task automatic test_round_robin;
        int g;
        logic [DW-1:0] exp_d;
        // Lone requester-1 read moves the pointer to 0 before the contention window.
        req_valid = 2'b10; req_we = 2'b00; req_addr = {4'd4, 4'd3};
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_lone got %b want 10", req_ready); end
        step();
        exp_prio = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = exp_prio;
            exp_d = (g == 0) ? ref_mem[3] : ref_mem[4];
            #1;
            checks++; if (req_ready !== 2'(1 << g)) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 2'(1 << g)); end
            step();
            checks++; if (rsp_valid !== 2'(1 << g) || rsp_data !== exp_d) begin
                errors++; $display("FAIL rr_rsp%0d got v=%b d=%h want %b %h", k, rsp_valid, rsp_data, 2'(1 << g), exp_d); end
            exp_prio = 1 - g;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_out_of_range;
        req_valid = 2'b10; req_we = 2'b00; req_addr = {4'd12, 4'd0};
        #1;
        checks++; if (req_ready !== 2'b10 || mem_en !== 1'b0) begin
            errors++; $display("FAIL oor_issue got ready=%b en=%b want 10 0", req_ready, mem_en); end
        step();
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b1, 32'd0}) begin
            errors++; $display("FAIL oor_rsp got v=%b e=%b d=%h want 10 1 0", rsp_valid, rsp_err, rsp_data); end
        exp_prio = 0;
    endtask

    task automatic test_clear;
        req_valid = 2'b10; req_we = 2'b10; req_addr = {4'd5, 4'd5}; req_wdata = {32'h1234_5678, 32'd0};
        step();
        req_valid = 2'b01; req_we = 2'b00;
        step();
        clr = 1'b1; req_addr = {4'd0, 4'd7};
        #1;
        checks++; if (req_ready !== 2'b00 || init_done !== 1'b1) begin
            errors++; $display("FAIL clr_ready got ready=%b done=%b want 00 1", req_ready, init_done); end
        checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 32'h1234_5678}) begin
            errors++; $display("FAIL clr_rsp got v=%b e=%b d=%h want 01 0 12345678", rsp_valid, rsp_err, rsp_data); end
        step();
        clr = 1'b0;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL clr_no_rsp got %b want 00", rsp_valid); end
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, req_ready} !== {1'b1, 1'b1, 4'(i), 32'd0, 2'b00}) begin
                errors++; $display("FAIL clr_init%0d got en=%b we=%b a=%0d d=%h ready=%b", i, mem_en, mem_we, mem_addr, mem_wdata, req_ready); end
            step();
            ref_mem[i] = '0;
        end
        #1;
        checks++; if (req_ready !== 2'b01 || mem_addr !== 4'd7 || mem_en !== 1'b1) begin
            errors++; $display("FAIL clr_resume got ready=%b a=%0d en=%b want 01 7 1", req_ready, mem_addr, mem_en); end
        step();
        req_valid = 2'b00;
        checks++; if ({rsp_valid, rsp_data} !== {2'b01, 32'd0}) begin
            errors++; $display("FAIL clr_resume_rsp got v=%b d=%h want 01 0", rsp_valid, rsp_data); end
        exp_prio = 1;
    endtask

    task automatic test_random;
        bit            have [2];
        bit            r_we [2];
        int            r_addr [2];
        logic [DW-1:0] r_wdata [2];
        int            g;
        bit            inr;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_ready;
        have[0] = 0; have[1] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!have[i] && $urandom_range(1, 0) == 1) begin
                    have[i]    = 1;
                    r_we[i]    = 1'($urandom_range(1, 0));
                    r_addr[i]  = $urandom_range(12, 0);
                    r_wdata[i] = $urandom;
                end
            end
            req_valid = {have[1], have[0]};
            req_we    = {r_we[1], r_we[0]};
            req_addr  = {4'(r_addr[1]), 4'(r_addr[0])};
            req_wdata = {r_wdata[1], r_wdata[0]};
            g = -1;
            if (have[0] && have[1]) g = exp_prio;
            else if (have[0])       g = 0;
            else if (have[1])       g = 1;
            exp_ready = (g < 0) ? 2'b00 : 2'(1 << g);
            inr   = (g >= 0) && (r_addr[g] < DEPTH);
            exp_d = (inr && !r_we[g]) ? ref_mem[r_addr[g]] : '0;
            #1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, exp_ready); end
            if (g >= 0) begin
                checks++; if (mem_en !== inr) begin errors++; $display("FAIL rnd_en c%0d got %b want %b", c, mem_en, inr); end
                if (inr) begin
                    checks++; if (mem_we !== r_we[g] || mem_addr !== 4'(r_addr[g]) || (r_we[g] && mem_wdata !== r_wdata[g])) begin
                        errors++; $display("FAIL rnd_mem c%0d got we=%b a=%0d d=%h want %b %0d %h", c, mem_we, mem_addr, mem_wdata, r_we[g], r_addr[g], r_wdata[g]); end
                end
            end
            step();
            if (g >= 0) begin
                checks++; if ({rsp_valid, rsp_err, rsp_data} !== {exp_ready, !inr, exp_d}) begin
                    errors++; $display("FAIL rnd_rsp c%0d got v=%b e=%b d=%h want %b %b %h", c, rsp_valid, rsp_err, rsp_data, exp_ready, !inr, exp_d); end
                if (inr && r_we[g]) ref_mem[r_addr[g]] = r_wdata[g];
                have[g]  = 0;
                exp_prio = 1 - g;
            end else begin
                checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rnd_idle c%0d got %b want 00", c, rsp_valid); end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_init;
        rst = 1'b1; req_valid = 2'b01; req_we = 2'b00; req_addr = {4'd0, 4'd1};
        #1;
        checks++; if (req_ready !== 2'b00 || mem_addr !== 4'd0) begin
            errors++; $display("FAIL rst_run got ready=%b a=%0d want 00 0", req_ready, mem_addr); end
        step();
        rst = 1'b0; req_valid = 2'b00;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_drop got %b want 00", rsp_valid); end
        for (int i = 0; i < 6; i++) step();
        #1;
        checks++; if (mem_addr !== 4'd6 || init_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_cnt got a=%0d done=%b want 6 0", mem_addr, init_done); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++; if ({mem_en, mem_we, mem_addr, init_done} !== {1'b1, 1'b1, 4'(i), 1'b0}) begin
                errors++; $display("FAIL rst_reinit%0d got en=%b we=%b a=%0d done=%b", i, mem_en, mem_we, mem_addr, init_done); end
            step();
        end
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL rst_reinit_done got %b want 1", init_done); end
        exp_prio = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_clear();
        test_random();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
